// File: rtl/clk_wiz_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_wiz_lock_ctrl
// Purpose  : Power-up and lock supervision for a clocking wizard. Sequences
//            the wizard reset, qualifies lock, ungates the output clocks and
//            then releases the downstream reset. Retries on lock timeout or
//            loss of lock, and latches a fault after too many failed attempts.
// Ports    : clk_in1     - free-running reference clock (only clock)
//            reset       - asynchronous active-high reset
//            locked      - wizard lock status (asynchronous, synchronized here)
//            restart     - single-cycle request to restart the sequence
//            wiz_resetn  - to wizard resetn
//            clk_gate_en - to wizard clk_gate_en
//            sys_rst     - active-high reset for wizard-clocked logic
//            ready       - high only in RUN
//            fault       - high only in FAULT
//            retry_cnt   - retries consumed in the current sequence
//            state       - debug encoding of the current state
// Revision : 1.0 - initial release
// ============================================================================
module clk_wiz_lock_ctrl #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 256,
  parameter int GATE_TO_RST_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3,
  localparam int c_retry_w = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic                 clk_in1,
  input  logic                 reset,
  input  logic                 locked,
  input  logic                 restart,
  output logic                 wiz_resetn,
  output logic                 clk_gate_en,
  output logic                 sys_rst,
  output logic                 ready,
  output logic                 fault,
  output logic [c_retry_w-1:0] retry_cnt,
  output logic [2:0]           state
);

  // One shared counter, sized to the largest interval it must measure.
  localparam int c_max_ab  = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int c_max_cd  = (LOCK_STABLE_CYCLES > GATE_TO_RST_CYCLES) ? LOCK_STABLE_CYCLES : GATE_TO_RST_CYCLES;
  localparam int c_max_all = (c_max_ab > c_max_cd) ? c_max_ab : c_max_cd;
  localparam int c_cnt_w   = (c_max_all > 1) ? $clog2(c_max_all) : 1;

  localparam logic [c_cnt_w-1:0]   c_rst_last     = c_cnt_w'(RST_PULSE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_timeout_last = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_stable_last  = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_gate_last    = c_cnt_w'(GATE_TO_RST_CYCLES - 1);
  localparam logic [c_retry_w-1:0] c_retry_max    = c_retry_w'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RST_MMCM  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_GATE_ON   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_retry_w-1:0] r_retry;
  logic [c_retry_w-1:0] w_retry_nxt;
  logic                 w_cnt_clr;
  logic                 r_lock_meta;
  logic                 r_lock_s;

  // Two-flop synchronizer for the asynchronous lock status.
  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_state <= ST_RST_MMCM;
      r_cnt   <= '0;
      r_retry <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    if (restart) begin
      // Restart overrides every transition, including staying in RST_MMCM.
      w_state_nxt = ST_RST_MMCM;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_RST_MMCM: begin
          if (r_cnt == c_rst_last) w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt = ST_STABLE;
          end else if (r_cnt == c_timeout_last) begin
            if (r_retry == c_retry_max) begin
              w_state_nxt = ST_FAULT;
            end else begin
              w_state_nxt = ST_RST_MMCM;
              w_retry_nxt = r_retry + 1'b1;
            end
          end
        end
        ST_STABLE: begin
          // A lock glitch does not consume a retry; it only restarts the timeout.
          if (!r_lock_s) begin
            w_state_nxt = ST_WAIT_LOCK;
          end else if (r_cnt == c_stable_last) begin
            w_state_nxt = ST_GATE_ON;
          end
        end
        ST_GATE_ON: begin
          if (!r_lock_s) begin
            w_state_nxt = ST_RST_MMCM;
          end else if (r_cnt == c_gate_last) begin
            w_state_nxt = ST_RUN;
            w_retry_nxt = '0;
          end
        end
        ST_RUN: begin
          if (!r_lock_s) w_state_nxt = ST_RST_MMCM;
        end
        ST_FAULT: begin
          w_state_nxt = ST_FAULT;
        end
        default: begin
          w_state_nxt = ST_RST_MMCM;
        end
      endcase
    end
    // A restart that stays in RST_MMCM still has to re-time the reset pulse.
    w_cnt_clr = restart || (w_state_nxt != r_state);
  end

  // Outputs decode only the state register, so no input reaches an output
  // combinationally.
  assign wiz_resetn  = (r_state != ST_RST_MMCM) && (r_state != ST_FAULT);
  assign clk_gate_en = (r_state == ST_GATE_ON) || (r_state == ST_RUN);
  assign sys_rst     = (r_state != ST_RUN);
  assign ready       = (r_state == ST_RUN);
  assign fault       = (r_state == ST_FAULT);
  assign retry_cnt   = r_retry;
  assign state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_clk_wiz_lock_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_wiz_lock_ctrl
// Purpose  : Directed self-checking bench for clk_wiz_lock_ctrl using small
//            parameters (pulse 4, timeout 32, stable 8, gate 2, retries 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_wiz_lock_ctrl;

  logic       clk_in1 = 1'b0;
  logic       reset;
  logic       locked;
  logic       restart;
  logic       wiz_resetn;
  logic       clk_gate_en;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int vectors     = 0;
  int miscompares = 0;

  clk_wiz_lock_ctrl #(
    .RST_PULSE_CYCLES    (4),
    .LOCK_TIMEOUT_CYCLES (32),
    .LOCK_STABLE_CYCLES  (8),
    .GATE_TO_RST_CYCLES  (2),
    .MAX_RETRIES         (2)
  ) dut (
    .clk_in1     (clk_in1),
    .reset       (reset),
    .locked      (locked),
    .restart     (restart),
    .wiz_resetn  (wiz_resetn),
    .clk_gate_en (clk_gate_en),
    .sys_rst     (sys_rst),
    .ready       (ready),
    .fault       (fault),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  always #5 clk_in1 = ~clk_in1;

  // Advance n rising edges; inputs and checks happen 1 time unit after the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_in1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic w, input logic g, input logic s,
                          input logic r, input logic f, input logic [1:0] rc, input logic [2:0] st);
    chk({tag, ".wiz_resetn"},  wiz_resetn,  w);
    chk({tag, ".clk_gate_en"}, clk_gate_en, g);
    chk({tag, ".sys_rst"},     sys_rst,     s);
    chk({tag, ".ready"},       ready,       r);
    chk({tag, ".fault"},       fault,       f);
    chk({tag, ".retry_cnt"},   retry_cnt,   rc);
    chk({tag, ".state"},       state,       st);
  endtask

  initial begin
    reset   = 1'b1;
    locked  = 1'b0;
    restart = 1'b0;
    step(3);
    chk_outs("reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);

    // ---------------- normal bring-up ----------------
    reset = 1'b0;
    step(3);
    chk("bringup.wiz_low_e3", wiz_resetn, 1'b0);
    step(1);
    chk("bringup.wiz_high_e4", wiz_resetn, 1'b1);
    chk("bringup.wait_lock", state, 3'd1);
    step(10);
    locked = 1'b1;
    step(2);
    chk("bringup.still_wait_e2", state, 3'd1);
    step(1);
    chk("bringup.stable_e3", state, 3'd2);
    step(7);
    chk("bringup.gate_off_e10", clk_gate_en, 1'b0);
    step(1);
    chk_outs("bringup.gate_on_e11", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3'd3);
    step(1);
    chk("bringup.not_ready_e12", ready, 1'b0);
    step(1);
    chk_outs("bringup.run_e13", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);

    // ---------------- loss of lock in RUN ----------------
    locked = 1'b0;
    step(2);
    chk("lol.ready_e2", ready, 1'b1);
    step(1);
    chk_outs("lol.e3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
    step(3);
    chk("lol.wiz_low_e6", wiz_resetn, 1'b0);
    step(1);
    chk("lol.wiz_high_e7", wiz_resetn, 1'b1);
    locked = 1'b1;
    step(3);
    chk("lol.relock_stable", state, 3'd2);
    step(7);
    chk("lol.relock_gate_off", clk_gate_en, 1'b0);
    step(1);
    chk("lol.relock_gate_on", clk_gate_en, 1'b1);
    step(2);
    chk_outs("lol.relock_run", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd4);

    // ---------------- lock glitch in STABLE ----------------
    locked = 1'b0;
    step(7);
    chk("glitch.wait_lock", state, 3'd1);
    locked = 1'b1;
    step(3);
    chk("glitch.stable", state, 3'd2);
    step(2);
    locked = 1'b0;
    step(2);
    chk("glitch.still_stable", state, 3'd2);
    step(1);
    chk("glitch.back_to_wait", state, 3'd1);
    chk("glitch.retry_kept", retry_cnt, 2'd0);
    locked = 1'b1;
    step(2);
    chk("glitch.wait_e2", state, 3'd1);
    step(1);
    chk("glitch.stable_e3", state, 3'd2);
    step(7);
    chk("glitch.gate_off_e10", clk_gate_en, 1'b0);
    step(1);
    chk("glitch.gate_on_e11", clk_gate_en, 1'b1);
    chk("glitch.retry", retry_cnt, 2'd0);
    step(2);
    chk("glitch.run", ready, 1'b1);

    // ---------------- restart in RUN ----------------
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk_outs("restart_run", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);
    step(3);
    chk("restart_run.rst_e3", state, 3'd0);
    step(1);
    chk("restart_run.wait_e4", state, 3'd1);

    // ---------------- async reset in GATE_ON ----------------
    step(1);
    chk("areset.stable", state, 3'd2);
    step(8);
    chk("areset.gate_on", state, 3'd3);
    chk("areset.gate_en_before", clk_gate_en, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("areset.async", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);

    // ---------------- timeout to fault ----------------
    locked = 1'b0;
    step(2);
    reset = 1'b0;
    step(3);
    chk("tmo.p1_low", wiz_resetn, 1'b0);
    step(1);
    chk("tmo.p1_high", wiz_resetn, 1'b1);
    step(31);
    chk("tmo.w1_e31", state, 3'd1);
    step(1);
    chk("tmo.retry1_state", state, 3'd0);
    chk("tmo.retry1_cnt", retry_cnt, 2'd1);
    step(3);
    chk("tmo.p2_low", wiz_resetn, 1'b0);
    step(1);
    chk("tmo.p2_high", wiz_resetn, 1'b1);
    step(31);
    chk("tmo.w2_e31", state, 3'd1);
    step(1);
    chk("tmo.retry2_cnt", retry_cnt, 2'd2);
    chk("tmo.p3_low_start", wiz_resetn, 1'b0);
    step(3);
    chk("tmo.p3_low", wiz_resetn, 1'b0);
    step(1);
    chk("tmo.p3_high", wiz_resetn, 1'b1);
    step(31);
    chk("tmo.w3_e31", state, 3'd1);
    step(1);
    chk_outs("tmo.fault", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5);
    step(10);
    chk_outs("tmo.fault_held", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd5);

    // ---------------- restart in FAULT ----------------
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    chk_outs("restart_fault", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
